flag_reg_stack: RTL and testbench
=================================

# flag_reg_stack

Parametrised condition-flag register with per-bit load enables, synchronous clear, and a LIFO shadow stack for saving and restoring flags across interrupts and subroutine calls. Holds the ALU status bits (Z, C, N, V by default) between the ALU and the control unit. It generalises the single-bit zero-flag register to WIDTH bits. It adds push/pop context save and sticky overflow/underflow error reporting.

## Interface
- WIDTH, 4, number of flag bits (bit 0 = Z, 1 = C, 2 = N, 3 = V)
- DEPTH, 4, shadow stack entries (≥ 1)
- LW, $clog2(DEPTH+1), level counter width (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flags_in  in  WIDTH  new flag values from ALU
- we  in  WIDTH  per-bit load enable (replaces single re)
- clear  in  1  synchronous clear of live flags
- push  in  1  save live flags onto stack
- pop  in  1  restore live flags from stack top
- err_clr  in  1  clear sticky error bits
- flags_out  out  WIDTH  live flags, registered
- level  out  LW  number of occupied stack entries
- full  out  1  level == DEPTH (combinational from level)
- empty  out  1  level == 0 (combinational from level)
- ovf  out  1  sticky: push attempted while full
- unf  out  1  sticky: pop attempted while empty

## Operation
- Reset (rst_n low, async): flags_out = 0, level = 0, ovf = 0, unf = 0; stack contents don't-care. empty = 1, full = 0.
- Per rising edge, decode:
  - push_ok = push & ~pop & ~full
  - pop_ok = pop & ~push & ~empty
- Live flag next value, priority high→low:
  1. clear → all zeros
  2. pop_ok → stack[level-1]
  3. otherwise → per bit: we[i] ? flags_in[i] : flags_out[i]
- pop_ok ignores we that cycle. Flag writes are not merged into restored flags.
- push_ok: stack[level] ← current flags_out (pre-update value); level + 1. The flag update in the same cycle still applies. This is the interrupt-entry case: the old context is saved while new flags are loaded.
- pop_ok: level − 1.
- push & pop in the same cycle: neither stack operation occurs, no error is raised, and the normal flag write/clear applies.
- push & ~pop & full: no stack change, ovf ← 1, and the flag write/clear applies normally.
- pop & ~push & empty: no stack change, unf ← 1, and the flag write/clear applies normally.
- clear does not affect the stack, level, or errors. clear combined with push_ok saves the old flags, then zeroes the live flags. clear combined with pop_ok decrements level, and flags become 0.
- err_clr zeroes ovf and unf. If a new error occurs in the same cycle, setting wins.
- level never exceeds DEPTH and never wraps below 0.

## Timing
- All outputs are registered except full and empty, which decode level combinationally.
- Write latency is 1 cycle: a we/flags_in sampled at edge n is visible on flags_out after edge n.
- Push→pop round trip: a pop issued the cycle after a push restores the value saved by that push.
- Back-to-back pushes and pops at 1 per cycle are supported with no bubbles.
- Reset assertion mid-operation takes effect immediately, without waiting for a clock edge. Deassertion is synchronised externally; the block samples normally from the first edge with rst_n high.

## Test plan
- Reset then write: rst_n low→high, we=4'b1111, flags_in=4'b1010 → flags_out=4'b1010 after 1 edge. Then we=4'b0001, flags_in=4'b0101 → flags_out=4'b1011.
- Push/modify/pop: flags=4'b0011, push=1 with we=4'hF, flags_in=4'b1100 → flags_out=4'b1100, level=1. Next cycle pop=1, we=4'hF, flags_in=4'hF → flags_out=4'b0011, level=0.
- Fill/overflow: DEPTH=4, push 4× with flags 1,2,3,4 → full=1, level=4. A 5th push → level stays 4, ovf=1. Pop 4× → flags_out sequence 4,3,2,1, then empty=1.
- Underflow and err_clr: from reset, pop=1 → unf=1, level=0, flags unchanged. err_clr=1 → unf=0. err_clr plus another empty pop in the same cycle → unf stays 1.
- Simultaneous events: push+pop with level=2, we=4'hF, flags_in=4'h6 → level=2, flags_out=4'h6, no error. clear+push with flags=4'h9 → stack top=4'h9, flags_out=0, level+1.
- Async reset mid-operation: level=3, ovf=1; drop rst_n between edges → flags_out=0, level=0, ovf=0 immediately, empty=1.

Source files
------------

// File: rtl/flag_reg_stack.sv
// rtl/flag_reg_stack.sv - condition-flag register with per-bit load enables and LIFO shadow stack
module flag_reg_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] flags_in,
    input  logic [WIDTH-1:0] we,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] flags_out,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic             push_ok;
    logic             pop_ok;
    logic             push_err;
    logic             pop_err;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    top_idx;
    logic [WIDTH-1:0] flags_nxt;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Simultaneous push and pop cancel each other without raising an error.
    assign push_ok  = push & ~pop & ~full;
    assign pop_ok   = pop & ~push & ~empty;
    assign push_err = push & ~pop & full;
    assign pop_err  = pop & ~push & empty;

    assign push_idx = IW'(level);
    assign top_idx  = IW'(level - 1'b1);

    always_comb begin
        flags_nxt = flags_out;
        if (clear) begin
            flags_nxt = '0;
        end else if (pop_ok) begin
            flags_nxt = stack[top_idx];
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (we[i]) begin
                    flags_nxt[i] = flags_in[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_out <= '0;
            level     <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            flags_out <= flags_nxt;
            if (push_ok) begin
                level <= level + 1'b1;
            end else if (pop_ok) begin
                level <= level - 1'b1;
            end
            // A new error in the same cycle as err_clr takes precedence.
            if (push_err) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (pop_err) begin
                unf <= 1'b1;
            end else if (err_clr) begin
                unf <= 1'b0;
            end
        end
    end

    // Stack storage carries no reset; entries above level are don't-care.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack[push_idx] <= flags_out;
        end
    end

endmodule

// File: tb/tb_flag_reg_stack.sv
// tb/tb_flag_reg_stack.sv - directed self-checking bench for flag_reg_stack
module tb_flag_reg_stack;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] flags_in;
    logic [WIDTH-1:0] we;
    logic             clear;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] flags_out;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    int n_checks = 0;
    int n_fail   = 0;

    flag_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flags_in  (flags_in),
        .we        (we),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .flags_out (flags_out),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] w, input logic [3:0] d, input logic c,
                         input logic pu, input logic po, input logic ec);
        we = w; flags_in = d; clear = c; push = pu; pop = po; err_clr = ec;
        @(posedge clk);
        #1;
        we = '0; flags_in = '0; clear = 0; push = 0; pop = 0; err_clr = 0;
    endtask

    initial begin
        rst_n = 0; we = '0; flags_in = '0; clear = 0; push = 0; pop = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", 32'(flags_out), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);
        rst_n = 1;

        drive(4'hF, 4'hA, 0, 0, 0, 0);
        chk("write_all", 32'(flags_out), 32'hA);
        drive(4'h1, 4'h5, 0, 0, 0, 0);
        chk("write_bit0", 32'(flags_out), 32'hB);

        drive(4'hF, 4'h3, 0, 0, 0, 0);
        drive(4'hF, 4'hC, 0, 1, 0, 0);
        chk("push_flags", 32'(flags_out), 32'hC);
        chk("push_level", 32'(level), 1);
        drive(4'hF, 4'hF, 0, 0, 1, 0);
        chk("pop_flags", 32'(flags_out), 32'h3);
        chk("pop_level", 32'(level), 0);
        chk("pop_empty", 32'(empty), 1);

        drive(4'hF, 4'h1, 0, 0, 0, 0);
        drive(4'hF, 4'h2, 0, 1, 0, 0);
        drive(4'hF, 4'h3, 0, 1, 0, 0);
        drive(4'hF, 4'h4, 0, 1, 0, 0);
        drive(4'hF, 4'h5, 0, 1, 0, 0);
        chk("fill_level", 32'(level), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_flags", 32'(flags_out), 32'h5);
        drive(4'h0, 4'h0, 0, 1, 0, 0);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_set", 32'(ovf), 1);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        chk("pop1", 32'(flags_out), 32'h4);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        chk("pop2", 32'(flags_out), 32'h3);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        chk("pop3", 32'(flags_out), 32'h2);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        chk("pop4", 32'(flags_out), 32'h1);
        chk("drain_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(ovf), 1);
        drive(4'h0, 4'h0, 0, 0, 0, 1);
        chk("ovf_clr", 32'(ovf), 0);

        drive(4'h0, 4'h0, 0, 0, 1, 0);
        chk("unf_set", 32'(unf), 1);
        chk("unf_level", 32'(level), 0);
        chk("unf_flags", 32'(flags_out), 32'h1);
        drive(4'h0, 4'h0, 0, 0, 0, 1);
        chk("unf_clr", 32'(unf), 0);
        drive(4'h0, 4'h0, 0, 0, 1, 1);
        chk("unf_set_wins", 32'(unf), 1);
        drive(4'h0, 4'h0, 0, 0, 0, 1);

        drive(4'h0, 4'h0, 0, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 1, 0, 0);
        chk("two_push_level", 32'(level), 2);
        drive(4'hF, 4'h6, 0, 1, 1, 0);
        chk("pushpop_level", 32'(level), 2);
        chk("pushpop_flags", 32'(flags_out), 32'h6);
        chk("pushpop_ovf", 32'(ovf), 0);
        chk("pushpop_unf", 32'(unf), 0);

        drive(4'hF, 4'h9, 0, 0, 0, 0);
        drive(4'h0, 4'h0, 1, 1, 0, 0);
        chk("clrpush_flags", 32'(flags_out), 0);
        chk("clrpush_level", 32'(level), 3);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        chk("clrpush_saved", 32'(flags_out), 32'h9);
        chk("clrpush_pop_level", 32'(level), 2);
        drive(4'hF, 4'hF, 1, 0, 1, 0);
        chk("clrpop_flags", 32'(flags_out), 0);
        chk("clrpop_level", 32'(level), 1);

        drive(4'h0, 4'h0, 0, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 1, 0, 0);
        drive(4'h0, 4'h0, 0, 0, 1, 0);
        drive(4'hF, 4'h7, 0, 0, 0, 0);
        chk("pre_rst_level", 32'(level), 3);
        chk("pre_rst_ovf", 32'(ovf), 1);
        chk("pre_rst_flags", 32'(flags_out), 32'h7);
        #3;
        rst_n = 0;
        #1;
        chk("async_flags", 32'(flags_out), 0);
        chk("async_level", 32'(level), 0);
        chk("async_ovf", 32'(ovf), 0);
        chk("async_empty", 32'(empty), 1);
        @(posedge clk);
        #1;
        rst_n = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
